beam_moments_calc: RTL and testbench

Computes per-frame beam-profile moments from the 160-word background-subtracted channel stream and emits a 4-word result packet. It sits directly downstream of the background-subtraction stage, on its `data_out_*` stream. Each input word carries two signed 16-bit channels: upper half = channel 2k, lower half = channel 2k+1, k = beat index. Results go to the UDP packer as a separate Avalon-ST packet.

---
 rtl/beam_moments_calc.sv | 167 ++++++++++++++++
 tb/tb_beam_moments_calc.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_moments_calc.sv
// Per-frame beam-profile moments (thresholded sum, first moment, raw peak) over a
// 160-beat two-channel-per-word stream, emitted as a 4-word Avalon-ST result packet.
module beam_moments_calc #(
    parameter int                 NCH_WORDS = 160,
    parameter logic signed [15:0] THRESH    = 16'sd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in_data,
    input  logic        data_in_valid,
    output logic        data_in_ready,
    input  logic        data_in_startofpacket,
    input  logic        data_in_endofpacket,
    input  logic [1:0]  data_in_empty,
    output logic [31:0] result_data,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        result_startofpacket,
    output logic        result_endofpacket,
    output logic [1:0]  result_empty
);
    localparam logic [8:0] NCH_LIM = 9'(NCH_WORDS);

    // S_LATCH is the one-cycle gap between the EOP beat landing and word 0 appearing.
    typedef enum logic [1:0] {S_ACC, S_LATCH, S_EMIT} state_t;

    state_t             state_reg, state_next;
    logic [1:0]         w_reg;
    logic signed [31:0] sum_reg, moment_reg;
    logic signed [15:0] peak_val_reg;
    logic [15:0]        peak_idx_reg;
    logic [8:0]         k_reg;
    logic               in_pkt_reg, restart_reg, long_reg, short_reg;
    logic [15:0]        frame_seq_reg;
    logic [31:0]        res_word_reg [4];

    logic sop, eop, beat_acc, beat_live, word_acc;
    logic unused_empty;

    assign sop           = data_in_startofpacket;
    assign eop           = data_in_endofpacket;
    assign data_in_ready = (state_reg == S_ACC);
    assign beat_acc      = data_in_valid && data_in_ready;
    assign beat_live     = beat_acc && (in_pkt_reg || sop);
    assign word_acc      = result_valid && result_ready;
    assign unused_empty  = ^data_in_empty;

    // An SOP beat starts from fresh accumulators rather than the registered ones.
    logic signed [31:0] sum_base, moment_base;
    logic signed [15:0] peak_val_base;
    logic [15:0]        peak_idx_base;
    logic [8:0]         k_base;

    assign sum_base      = sop ? 32'sd0 : sum_reg;
    assign moment_base   = sop ? 32'sd0 : moment_reg;
    assign peak_val_base = sop ? 16'sh8000 : peak_val_reg;
    assign peak_idx_base = sop ? 16'd0 : peak_idx_reg;
    assign k_base        = sop ? 9'd0 : k_reg;

    logic signed [15:0] samp     [2];
    logic signed [31:0] samp_thr [2];
    logic [15:0]        lane_idx [2];
    logic signed [31:0] lane_mom [2];

    assign samp[0] = data_in_data[31:16];
    assign samp[1] = data_in_data[15:0];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign samp_thr[gi] = (samp[gi] > THRESH) ? 32'(samp[gi]) : 32'sd0;
            assign lane_idx[gi] = {6'd0, k_base, 1'(gi)};
            assign lane_mom[gi] = samp_thr[gi] * $signed({16'd0, lane_idx[gi]});
        end
    endgenerate

    logic               in_range;
    logic signed [31:0] sum_next, moment_next;
    logic signed [15:0] peak_val_next;
    logic [15:0]        peak_idx_next;
    logic [8:0]         k_next;

    always_comb begin
        in_range      = (k_base < NCH_LIM);
        sum_next      = sum_base;
        moment_next   = moment_base;
        peak_val_next = peak_val_base;
        peak_idx_next = peak_idx_base;
        k_next        = (k_base == 9'd511) ? k_base : k_base + 9'd1;
        if (in_range) begin
            sum_next    = sum_base + samp_thr[0] + samp_thr[1];
            moment_next = moment_base + lane_mom[0] + lane_mom[1];
            // Lane a is checked first so the lower channel index wins ties.
            if (samp[0] > peak_val_next) begin
                peak_val_next = samp[0];
                peak_idx_next = lane_idx[0];
            end
            if (samp[1] > peak_val_next) begin
                peak_val_next = samp[1];
                peak_idx_next = lane_idx[1];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_ACC:   if (beat_live && eop) state_next = S_LATCH;
            S_LATCH: state_next = S_EMIT;
            S_EMIT:  if (word_acc && (w_reg == 2'd3)) state_next = S_ACC;
            default: state_next = S_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_ACC;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_reg         <= 2'd0;
            sum_reg       <= '0;
            moment_reg    <= '0;
            peak_val_reg  <= '0;
            peak_idx_reg  <= '0;
            k_reg         <= '0;
            in_pkt_reg    <= 1'b0;
            restart_reg   <= 1'b0;
            long_reg      <= 1'b0;
            short_reg     <= 1'b0;
            frame_seq_reg <= '0;
            for (int i = 0; i < 4; i++) res_word_reg[i] <= '0;
        end else begin
            if (beat_live) begin
                sum_reg      <= sum_next;
                moment_reg   <= moment_next;
                peak_val_reg <= peak_val_next;
                peak_idx_reg <= peak_idx_next;
                k_reg        <= k_next;
                in_pkt_reg   <= !eop;
                if (sop) restart_reg <= in_pkt_reg;
                long_reg     <= (sop ? 1'b0 : long_reg) | !in_range;
                short_reg    <= eop ? (k_next < NCH_LIM) : (sop ? 1'b0 : short_reg);
            end
            if (state_reg == S_LATCH) begin
                res_word_reg[0] <= sum_reg;
                res_word_reg[1] <= moment_reg;
                res_word_reg[2] <= {peak_idx_reg, peak_val_reg};
                res_word_reg[3] <= {frame_seq_reg, 13'd0, restart_reg, long_reg, short_reg};
                w_reg           <= 2'd0;
            end else if (word_acc) begin
                w_reg <= w_reg + 2'd1;
                if (w_reg == 2'd3) frame_seq_reg <= frame_seq_reg + 16'd1;
            end
        end
    end

    assign result_valid         = (state_reg == S_EMIT);
    assign result_data          = result_valid ? res_word_reg[w_reg] : 32'd0;
    assign result_startofpacket = result_valid && (w_reg == 2'd0);
    assign result_endofpacket   = result_valid && (w_reg == 2'd3);
    assign result_empty         = 2'd0;
endmodule

// File: tb/tb_beam_moments_calc.sv
// Randomised bench for beam_moments_calc: two instances (THRESH 0 and 50) driven in
// lockstep and checked against a channel-level moments model.
module tb_beam_moments_calc;
    localparam int NCH = 160;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid, in_sop, in_eop;
    logic [1:0]  in_empty;
    logic        res_ready;
    logic        in_ready [2];
    logic [31:0] r_data   [2];
    logic        r_valid  [2];
    logic        r_sop    [2];
    logic        r_eop    [2];
    logic [1:0]  r_empty  [2];

    beam_moments_calc #(.NCH_WORDS(NCH), .THRESH(16'sd0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .data_in_data(in_data), .data_in_valid(in_valid), .data_in_ready(in_ready[0]),
        .data_in_startofpacket(in_sop), .data_in_endofpacket(in_eop), .data_in_empty(in_empty),
        .result_data(r_data[0]), .result_valid(r_valid[0]), .result_ready(res_ready),
        .result_startofpacket(r_sop[0]), .result_endofpacket(r_eop[0]), .result_empty(r_empty[0])
    );

    beam_moments_calc #(.NCH_WORDS(NCH), .THRESH(16'sd50)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .data_in_data(in_data), .data_in_valid(in_valid), .data_in_ready(in_ready[1]),
        .data_in_startofpacket(in_sop), .data_in_endofpacket(in_eop), .data_in_empty(in_empty),
        .result_data(r_data[1]), .result_valid(r_valid[1]), .result_ready(res_ready),
        .result_startofpacket(r_sop[1]), .result_endofpacket(r_eop[1]), .result_empty(r_empty[1])
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          frame_ch [0:399];
    logic [31:0] exp_w [2][4];
    int          exp_seq = 0;
    int          last_cycles = 0;

    task automatic fill_const(input int v);
        for (int i = 0; i < 400; i++) frame_ch[i] = v;
    endtask

    task automatic fill_random(input int lo, input int hi);
        for (int i = 0; i < 400; i++) frame_ch[i] = lo + int'($urandom_range(0, hi - lo));
    endtask

    // Reference: walk the channels in order; threshold for sum/moment, raw samples for peak.
    task automatic build_expected(input int nb, input bit restart);
        for (int t = 0; t < 2; t++) begin
            int th; longint sum; longint mom; int pv; int pi; int used;
            th = (t == 0) ? 0 : 50;
            sum = 0; mom = 0; pv = -32768; pi = 0;
            used = (nb < NCH) ? nb : NCH;
            for (int i = 0; i < 2 * used; i++) begin
                if (frame_ch[i] > th) begin
                    sum += frame_ch[i];
                    mom += longint'(frame_ch[i]) * i;
                end
                if (frame_ch[i] > pv) begin
                    pv = frame_ch[i];
                    pi = i;
                end
            end
            exp_w[t][0] = sum[31:0];
            exp_w[t][1] = mom[31:0];
            exp_w[t][2] = {pi[15:0], pv[15:0]};
            exp_w[t][3] = {exp_seq[15:0], 13'd0, restart, (nb > NCH), (nb < NCH)};
        end
    endtask

    task automatic send_beats(input int nb, input bit sop_first, input bit eop_last, input bit gaps);
        for (int b = 0; b < nb; b++) begin
            bit acc; int guard;
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = {frame_ch[2*b][15:0], frame_ch[2*b+1][15:0]};
            in_sop   = sop_first && (b == 0);
            in_eop   = eop_last && (b == nb - 1);
            acc = 1'b0; guard = 0;
            while (!acc) begin
                @(negedge clk);
                acc = in_ready[0];
                @(posedge clk); #1;
                guard++;
                if (!acc && guard > 2000) begin
                    n_vec++; n_err++;
                    $display("FAIL send_timeout beat=%0d data_in_ready=%b required=1", b, in_ready[0]);
                    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    // bp_mode: 0 ready held high, 1 ready pattern 1-0-0-1, 2 random ready.
    task automatic collect(input int bp_mode, input bit chk_lat);
        int w; int guard; int lat; bit seen; int cyc;
        w = 0; guard = 0; lat = 0; seen = 1'b0; cyc = 0;
        while (w < 4) begin
            case (bp_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
            cyc++;
            @(negedge clk);
            if (r_valid[0] || r_valid[1]) begin
                if (!seen && chk_lat) begin
                    n_vec++;
                    if (lat !== 1) begin
                        n_err++;
                        $display("FAIL eop_to_w0_latency got=%0d required=1", lat);
                    end
                end
                seen = 1'b1;
                for (int t = 0; t < 2; t++) begin
                    n_vec++;
                    if (r_valid[t] !== 1'b1 || in_ready[t] !== 1'b0) begin
                        n_err++;
                        $display("FAIL emit_handshake inst=%0d w=%0d valid=%b in_ready=%b required valid=1 in_ready=0",
                                 t, w, r_valid[t], in_ready[t]);
                    end
                end
                if (res_ready) begin
                    for (int t = 0; t < 2; t++) begin
                        n_vec++;
                        if (r_data[t] !== exp_w[t][w] || r_sop[t] !== (w == 0) || r_eop[t] !== (w == 3)) begin
                            n_err++;
                            $display("FAIL result_word inst=%0d w=%0d got=%h sop=%b eop=%b required=%h sop=%b eop=%b",
                                     t, w, r_data[t], r_sop[t], r_eop[t], exp_w[t][w], (w == 0), (w == 3));
                        end
                    end
                    w++;
                end
            end else if (!seen) begin
                lat++;
            end
            @(posedge clk); #1;
            guard++;
            if (w < 4 && guard > 1000) begin
                n_vec++; n_err++;
                $display("FAIL collect_timeout words=%0d required=4", w);
                res_ready = 1'b1;
                return;
            end
        end
        last_cycles = cyc;
        $display("pkt seq=%0d t0: %h %h %h %h  t50: %h %h %h %h", exp_seq,
                 exp_w[0][0], exp_w[0][1], exp_w[0][2], exp_w[0][3],
                 exp_w[1][0], exp_w[1][1], exp_w[1][2], exp_w[1][3]);
        exp_seq = (exp_seq + 1) & 16'hffff;
        res_ready = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        for (int t = 0; t < 2; t++) begin
            n_vec++;
            if (in_ready[t] !== 1'b1 || r_valid[t] !== 1'b0 || r_data[t] !== 32'd0 ||
                r_sop[t] !== 1'b0 || r_eop[t] !== 1'b0 || r_empty[t] !== 2'd0) begin
                n_err++;
                $display("FAIL %s inst=%0d in_ready=%b valid=%b data=%h sop=%b eop=%b empty=%0d required 1,0,0,0,0,0",
                         tag, t, in_ready[t], r_valid[t], r_data[t], r_sop[t], r_eop[t], r_empty[t]);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_data = '0; in_empty = 2'b11; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_during");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle("reset_after");
    endtask

    task automatic test_uniform;
        fill_const(100);
        build_expected(NCH, 1'b0);
        send_beats(NCH, 1'b1, 1'b1, 1'b0);
        collect(0, 1'b1);
        n_vec++;
        if (last_cycles !== 5) begin
            n_err++;
            $display("FAIL emit_duration cycles=%0d required=5", last_cycles);
        end
        check_idle("ready_after_emit");
    endtask

    task automatic test_spike;
        fill_const(-20);
        frame_ch[201] = 5000;
        build_expected(NCH, 1'b0);
        send_beats(NCH, 1'b1, 1'b1, 1'b1);
        collect(2, 1'b0);
    endtask

    task automatic test_threshold;
        fill_const(40);
        frame_ch[10] = 300;
        frame_ch[11] = 300;
        build_expected(NCH, 1'b0);
        send_beats(NCH, 1'b1, 1'b1, 1'b0);
        collect(0, 1'b0);
    endtask

    task automatic test_length;
        fill_random(-2000, 2000);
        build_expected(150, 1'b0);
        send_beats(150, 1'b1, 1'b1, 1'b1);
        collect(2, 1'b0);
        fill_random(-2000, 2000);
        for (int i = 320; i < 340; i++) frame_ch[i] = 30000;
        build_expected(170, 1'b0);
        send_beats(170, 1'b1, 1'b1, 1'b0);
        collect(0, 1'b0);
        fill_random(-2000, 2000);
        build_expected(NCH, 1'b0);
        send_beats(NCH, 1'b1, 1'b1, 1'b0);
        collect(0, 1'b0);
    endtask

    task automatic test_restart;
        fill_random(1000, 30000);
        send_beats(80, 1'b1, 1'b0, 1'b0);
        fill_random(-3000, 3000);
        build_expected(NCH, 1'b1);
        send_beats(NCH, 1'b1, 1'b1, 1'b1);
        collect(2, 1'b0);
    endtask

    task automatic test_back_to_back;
        fill_random(-32768, 32767);
        build_expected(NCH, 1'b0);
        send_beats(NCH, 1'b1, 1'b1, 1'b0);
        fill_random(-32768, 32767);
        fork
            send_beats(NCH, 1'b1, 1'b1, 1'b0);
            collect(1, 1'b0);
        join
        build_expected(NCH, 1'b0);
        collect(0, 1'b0);
    endtask

    task automatic test_reset_mid_emit;
        int guard;
        fill_random(-500, 5000);
        build_expected(NCH, 1'b0);
        send_beats(NCH, 1'b1, 1'b1, 1'b0);
        res_ready = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!r_valid[0] && guard < 20);
        @(posedge clk); #1;
        for (int t = 0; t < 2; t++) begin
            n_vec++;
            if (r_valid[t] !== 1'b1 || r_data[t] !== exp_w[t][1]) begin
                n_err++;
                $display("FAIL pre_reset_w1 inst=%0d valid=%b got=%h required valid=1 data=%h",
                         t, r_valid[t], r_data[t], exp_w[t][1]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        check_idle("reset_mid_emit");
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_seq = 0;
        fill_random(-32768, 32767);
        build_expected(NCH, 1'b0);
        send_beats(NCH, 1'b1, 1'b1, 1'b1);
        collect(2, 1'b0);
    endtask

    task automatic test_random;
        for (int it = 0; it < 4; it++) begin
            int nb;
            fill_random(-32768, 32767);
            send_beats(3, 1'b0, 1'b1, 1'b0);
            nb = int'($urandom_range(120, 175));
            fill_random(-32768, 32767);
            build_expected(nb, 1'b0);
            send_beats(nb, 1'b1, 1'b1, 1'b1);
            collect(2, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_spike();
        test_threshold();
        test_length();
        test_restart();
        test_back_to_back();
        test_reset_mid_emit();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
